countdown_multi: RTL and testbench

- N-channel BCD hh:mm:ss countdown timer with per-channel alarm ringing. Supersedes the single-channel countdown.
- Internal prescaler generates the 1 s tick. Each channel has its own run/pause/ring state machine. Commands are addressed through SEL.
- Alarm duration is a parameter. Lives in the clock/alarm datapath, feeding the display mux and buzzer driver.

---
 rtl/countdown_multi.sv | 232 +++++++++++++++++++++++
 tb/tb_countdown_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_multi.sv
// countdown_multi
//   N-channel BCD hh:mm:ss countdown timer with a per-channel alarm.
//   A free-running prescaler makes the 1 s tick. Each channel has its own
//   IDLE/RUN/PAUSE/RINGING state machine. Load, start and stop commands act
//   only on the channel addressed by SEL.
//
// Ports
//   CP            clock, all state updates on the rising edge
//   CR            synchronous reset, active-high, overrides every other input
//   SEL           channel addressed by PE/START/STOP and shown on Q_*
//   PE            load D_H/D_M/D_S into channel SEL (checked for valid BCD)
//   D_H/D_M/D_S   BCD load data for hours, minutes and seconds
//   START/STOP    start/resume or pause channel SEL
//   CS            per-channel alarm silence, level sampled every cycle
//   Q_H/Q_M/Q_S   value of channel SEL, combinational mux (0 when SEL>=N_CH)
//   RUN/TC        per-channel registered "running" and "ringing" flags
//   RING          OR of TC
//   ERR           one-cycle registered pulse for a rejected load or START
module countdown_multi #(
  parameter int         N_CH      = 4,
  parameter int         SEL_W     = 2,
  parameter int         CLK_DIV   = 50000000,
  parameter int         RING_SECS = 60,
  parameter logic [7:0] HOUR_MAX  = 8'h23
) (
  input  logic             CP,
  input  logic             CR,
  input  logic [SEL_W-1:0] SEL,
  input  logic             PE,
  input  logic [7:0]       D_H,
  input  logic [7:0]       D_M,
  input  logic [7:0]       D_S,
  input  logic             START,
  input  logic             STOP,
  input  logic [N_CH-1:0]  CS,
  output logic [7:0]       Q_H,
  output logic [7:0]       Q_M,
  output logic [7:0]       Q_S,
  output logic [N_CH-1:0]  RUN,
  output logic [N_CH-1:0]  TC,
  output logic             RING,
  output logic             ERR
);

  localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [7:0]     RING_INIT  = 8'(RING_SECS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RING  = 2'd3
  } state_e;

  // One BCD digit pair is valid when the low digit is 0..9 and the high
  // digit does not exceed hi_max.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [3:0] hi_max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= hi_max);
  endfunction

  // Decrement one BCD pair, 00 wraps to 59 (the caller handles the borrow).
  function automatic logic [7:0] pair_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) begin
      r = {v[7:4], v[3:0] - 4'd1};
    end else if (v[7:4] != 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = 8'h59;
    end
    return r;
  endfunction

  // hh:mm:ss minus one second with borrow; saturates at 00:00:00.
  function automatic logic [23:0] hms_dec(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    if (v != 24'h000000) begin
      r[7:0] = pair_dec(v[7:0]);
      if (v[7:0] == 8'h00) begin
        r[15:8] = pair_dec(v[15:8]);
        if (v[15:8] == 8'h00) begin
          r[23:16] = pair_dec(v[23:16]);
        end else begin
          r[23:16] = v[23:16];
        end
      end else begin
        r[15:8] = v[15:8];
      end
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_s;
  logic [23:0]     val_q   [N_CH];
  logic [23:0]     val_d   [N_CH];
  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [7:0]      ring_q  [N_CH];
  logic [7:0]      ring_d  [N_CH];
  logic [N_CH-1:0] run_q, tc_q;
  logic            err_q, err_d;
  logic [N_CH-1:0] hit_s;
  logic            load_ok_s;
  logic [23:0]     q_s;

  // Prescaler: tick in the cycle where the count sits at CLK_DIV-1.
  always_comb begin
    presc_d = presc_q;
    tick_s  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_s  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Channel address decode and load-data validation.
  always_comb begin
    hit_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit_s[i] = (SEL == SEL_W'(i));
    end
    load_ok_s = bcd_ok(D_S, 4'd5) && bcd_ok(D_M, 4'd5) && bcd_ok(D_H, 4'd9)
                && (D_H <= HOUR_MAX);
  end

  // Per-channel next state; priority PE > CS > STOP > START > tick.
  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      val_d[i]   = val_q[i];
      state_d[i] = state_q[i];
      ring_d[i]  = ring_q[i];
      if (hit_s[i] && PE) begin
        if (load_ok_s) begin
          val_d[i]   = {D_H, D_M, D_S};
          state_d[i] = ST_IDLE;
        end else begin
          err_d = 1'b1;
        end
      end else if (CS[i] && (state_q[i] == ST_RING)) begin
        state_d[i] = ST_IDLE;
      end else if (hit_s[i] && STOP && (state_q[i] == ST_RUN)) begin
        state_d[i] = ST_PAUSE;
      end else if (hit_s[i] && START &&
                   ((state_q[i] == ST_IDLE) || (state_q[i] == ST_PAUSE))) begin
        if (val_q[i] != 24'h000000) begin
          state_d[i] = ST_RUN;
        end else begin
          err_d = 1'b1;
        end
      end else if (tick_s) begin
        case (state_q[i])
          ST_RUN: begin
            // Expiry and entry into RINGING happen on the same edge.
            if (val_q[i] == 24'h000001) begin
              val_d[i]   = 24'h000000;
              state_d[i] = ST_RING;
              ring_d[i]  = RING_INIT;
            end else begin
              val_d[i] = hms_dec(val_q[i]);
            end
          end
          ST_RING: begin
            if (ring_q[i] == 8'd1) begin
              state_d[i] = ST_IDLE;
            end else begin
              ring_d[i] = ring_q[i] - 8'd1;
            end
          end
          default: begin
            state_d[i] = state_q[i];
          end
        endcase
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CP) begin
    if (CR) begin
      presc_q <= '0;
      run_q   <= '0;
      tc_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        val_q[i]   <= 24'h000000;
        state_q[i] <= ST_IDLE;
        ring_q[i]  <= 8'd0;
      end
    end else begin
      presc_q <= presc_d;
      err_q   <= err_d;
      for (int i = 0; i < N_CH; i++) begin
        val_q[i]   <= val_d[i];
        state_q[i] <= state_d[i];
        ring_q[i]  <= ring_d[i];
        run_q[i]   <= (state_d[i] == ST_RUN);
        tc_q[i]    <= (state_d[i] == ST_RING);
      end
    end
  end

  // Display mux of the selected channel; out-of-range SEL shows zero.
  always_comb begin
    q_s = 24'h000000;
    for (int i = 0; i < N_CH; i++) begin
      if (hit_s[i]) begin
        q_s = val_q[i];
      end else begin
        q_s = q_s;
      end
    end
  end

  assign Q_H  = q_s[23:16];
  assign Q_M  = q_s[15:8];
  assign Q_S  = q_s[7:0];
  assign RUN  = run_q;
  assign TC   = tc_q;
  assign RING = |tc_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_countdown_multi.sv
// Directed bench for countdown_multi. Main instance runs with a tick every
// cycle and a 3-tick alarm; a second instance with CLK_DIV=3 and N_CH=3
// covers prescaler phase after reset and out-of-range SEL.
// Expected values are queued when stimulus is applied and popped for
// comparison once the DUT has produced the response.
module tb_countdown_multi;
  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic       cr, pe, start, stop;
  logic [1:0] sel;
  logic [7:0] dh, dm, ds;
  logic [3:0] cs;
  logic [7:0] qh, qm, qs;
  logic [3:0] run, tc;
  logic       ring, err;

  logic [1:0] sel2;
  logic       pe2, start2;
  logic [7:0] qh2, qm2, qs2;
  logic [2:0] run2, tc2;
  logic       ring2, err2;

  int checks = 0;
  int failures = 0;
  int cnt;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  countdown_multi #(.N_CH(4), .SEL_W(2), .CLK_DIV(1), .RING_SECS(3), .HOUR_MAX(8'h23)) u_dut (
    .CP(cp), .CR(cr), .SEL(sel), .PE(pe), .D_H(dh), .D_M(dm), .D_S(ds),
    .START(start), .STOP(stop), .CS(cs), .Q_H(qh), .Q_M(qm), .Q_S(qs),
    .RUN(run), .TC(tc), .RING(ring), .ERR(err));

  countdown_multi #(.N_CH(3), .SEL_W(2), .CLK_DIV(3), .RING_SECS(2), .HOUR_MAX(8'h23)) u_div (
    .CP(cp), .CR(cr), .SEL(sel2), .PE(pe2), .D_H(dh), .D_M(dm), .D_S(ds),
    .START(start2), .STOP(1'b0), .CS(3'b000), .Q_H(qh2), .Q_M(qm2), .Q_S(qs2),
    .RUN(run2), .TC(tc2), .RING(ring2), .ERR(err2));

  function automatic logic [31:0] qv();
    return {8'h00, qh, qm, qs};
  endfunction

  function automatic logic [31:0] qv2();
    return {8'h00, qh2, qm2, qs2};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge cp);
      #1;
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty: observed=%h with no expected value queued", obs);
    end else begin
      x = sb_q.pop_front();
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic load(input logic [1:0] ch, input logic [23:0] v);
    sel = ch;
    {dh, dm, ds} = v;
    pe = 1'b1;
    step(1);
    pe = 1'b0;
  endtask

  task automatic go(input logic [1:0] ch);
    sel = ch;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    cr = 1'b1; pe = 1'b0; start = 1'b0; stop = 1'b0; sel = 2'd0;
    dh = 8'h00; dm = 8'h00; ds = 8'h00; cs = 4'b0000;
    sel2 = 2'd0; pe2 = 1'b0; start2 = 1'b0;

    // Reset state
    expect_v("rst_q", 32'h0); expect_v("rst_run", 32'h0);
    expect_v("rst_tc", 32'h0); expect_v("rst_ring_err", 32'h0);
    step(2);
    cr = 1'b0;
    check_v(qv()); check_v(32'(run)); check_v(32'(tc)); check_v({30'd0, ring, err});

    // Borrow chain on ch0
    expect_v("ld_ch0", 32'h010000);
    load(2'd0, 24'h010000);
    check_v(qv());
    expect_v("start_ch0_run", 32'h1);
    go(2'd0);
    check_v(32'(run[0]));
    expect_v("borrow_1tick", 32'h005959);
    step(1);
    check_v(qv());
    expect_v("pre_expiry_q", 32'h000001); expect_v("pre_expiry_tc", 32'h0);
    step(3598);
    check_v(qv()); check_v(32'(tc[0]));
    expect_v("expiry_tc", 32'h1); expect_v("expiry_q", 32'h0); expect_v("expiry_run", 32'h0);
    step(1);
    check_v(32'(tc[0])); check_v(qv()); check_v(32'(run[0]));
    expect_v("ring_still", 32'h1);
    step(2);
    check_v(32'(ring));
    expect_v("ring_timeout", 32'h0);
    step(1);
    check_v(32'(tc[0]));

    // Ring duration on ch1
    load(2'd1, 24'h000002);
    go(2'd1);
    expect_v("ch1_one", 32'h000001);
    step(1);
    check_v(qv());
    step(1);
    expect_v("tc1_ring_cycles", 32'd3);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (tc[1]) cnt++;
      step(1);
    end
    check_v(32'(cnt));

    // Silence ch1 on its second ring tick
    load(2'd1, 24'h000002);
    go(2'd1);
    step(2);
    step(1);
    cs = 4'b0010;
    expect_v("cs_silence_tc", 32'h0); expect_v("cs_silence_q", 32'h0);
    step(1);
    cs = 4'b0000;
    check_v(32'(tc[1])); check_v(qv());

    // Pause / resume on ch2
    load(2'd2, 24'h000010);
    go(2'd2);
    expect_v("run4_q", 32'h000006);
    step(4);
    check_v(qv());
    stop = 1'b1;
    expect_v("stop_q", 32'h000006); expect_v("stop_run", 32'h0);
    step(1);
    stop = 1'b0;
    check_v(qv()); check_v(32'(run[2]));
    expect_v("pause_hold", 32'h000006);
    step(20);
    check_v(qv());
    expect_v("resume_run", 32'h1); expect_v("resume_q", 32'h000006);
    go(2'd2);
    check_v(32'(run[2])); check_v(qv());
    expect_v("resume5_q", 32'h000001); expect_v("resume5_tc", 32'h0);
    step(5);
    check_v(qv()); check_v(32'(tc[2]));
    expect_v("resume_expiry_tc", 32'h1);
    step(1);
    check_v(32'(tc[2]));
    step(3);

    // Rejected commands
    expect_v("ld_valid_err", 32'h0); expect_v("ld_valid_q", 32'h123456);
    load(2'd2, 24'h123456);
    check_v(32'(err)); check_v(qv());
    expect_v("bad_s_err", 32'h1); expect_v("bad_s_q", 32'h123456);
    load(2'd2, 24'h000060);
    check_v(32'(err)); check_v(qv());
    expect_v("err_one_cycle", 32'h0);
    step(1);
    check_v(32'(err));
    expect_v("bad_h_err", 32'h1); expect_v("bad_h_q", 32'h123456);
    load(2'd2, 24'h240000);
    check_v(32'(err)); check_v(qv());
    expect_v("bad_m_digit_err", 32'h1);
    load(2'd2, 24'h005A00);
    check_v(32'(err));
    expect_v("max_ok_err", 32'h0); expect_v("max_ok_q", 32'h235959);
    load(2'd2, 24'h235959);
    check_v(32'(err)); check_v(qv());
    load(2'd2, 24'h000000);
    expect_v("start_zero_err", 32'h1); expect_v("start_zero_run", 32'h0);
    go(2'd2);
    check_v(32'(err)); check_v(32'(run[2]));

    // Independence of ch0 and ch3
    load(2'd0, 24'h000050);
    go(2'd0);
    load(2'd3, 24'h000100);
    go(2'd3);
    step(1);
    expect_v("ind_ch3_q", 32'h000059);
    check_v(qv());
    sel = 2'd0;
    #1;
    expect_v("ind_ch0_q", 32'h000047);
    check_v(qv());
    expect_v("ind_ch0_load", 32'h000020); expect_v("ind_ch0_idle", 32'h0);
    load(2'd0, 24'h000020);
    check_v(qv()); check_v(32'(run[0]));
    sel = 2'd3;
    #1;
    expect_v("ind_ch3_tick", 32'h000058); expect_v("ind_ch3_run", 32'h1);
    check_v(qv()); check_v(32'(run[3]));

    // Reset mid-count
    cr = 1'b1;
    expect_v("rst2_q", 32'h0); expect_v("rst2_run", 32'h0);
    expect_v("rst2_tc_err", 32'h0); expect_v("rst2_div", 32'h0);
    step(2);
    cr = 1'b0;
    check_v(qv()); check_v(32'(run)); check_v({27'd0, tc, err});
    check_v({24'd0, run2, tc2, ring2, err2});

    // Prescaler restarts on reset (CLK_DIV=3 instance)
    sel2 = 2'd0;
    {dh, dm, ds} = 24'h000009;
    pe2 = 1'b1;
    step(1);
    pe2 = 1'b0;
    start2 = 1'b1;
    expect_v("div_start_q", 32'h000009); expect_v("div_start_run", 32'h1);
    step(1);
    start2 = 1'b0;
    check_v(qv2()); check_v(32'(run2[0]));
    expect_v("div_first_tick", 32'h000008);
    step(1);
    check_v(qv2());
    expect_v("div_between", 32'h000008);
    step(2);
    check_v(qv2());
    expect_v("div_second_tick", 32'h000007);
    step(1);
    check_v(qv2());

    // SEL beyond N_CH: shows zero, commands ignored without ERR
    sel2 = 2'd3;
    #1;
    expect_v("sel_oor_q", 32'h0);
    check_v(qv2());
    {dh, dm, ds} = 24'h000060;
    pe2 = 1'b1;
    expect_v("sel_oor_err", 32'h0);
    step(1);
    pe2 = 1'b0;
    check_v(32'(err2));

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL sb_leftover: observed=%0d entries expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
